lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
- Leaky integrate-and-fire postsynaptic neuron. It sits directly upstream of the STDP timing/weight stage.
- Consumes the same 4-bit pre_spike vector and the packed 16-bit weight bus that the STDP stage produces.
- Produces the single-cycle post_spike pulse the STDP stage timestamps.
- Closes the pre → neuron → STDP → weight loop.

Parameters:
- NUM_PRE, 4, number of presynaptic inputs.
- W_WIDTH, 4, bits per synaptic weight (unsigned).
- V_WIDTH, 8, membrane potential width (unsigned).
- THRESHOLD, 32, firing threshold; fire when v_next >= THRESHOLD. Legal range 1..2^V_WIDTH-1.
- LEAK_SHIFT, 3, leak per cycle = v >> LEAK_SHIFT.
- REFRAC_CYCLES, 4, refractory length in cycles. Legal range 1..15.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, synchronous, active-low.
- enable, input, 1, advance neuron when high; freeze all state when low.
- pre_spike, input, NUM_PRE, presynaptic spike strobes for the current cycle.
- weight, input, NUM_PRE*W_WIDTH, packed weights. Neuron 0 at [15:12], neuron 1 at [11:8], neuron 2 at [7:4], neuron 3 at [3:0].
- post_spike, output, 1, registered one-cycle fire pulse.
- membrane, output, V_WIDTH, current membrane potential (register value).
- refractory, output, 1, high while in REFRACT state.
- spike_count, output, 8, saturating count of fires since reset.

Behaviour:
- Reset (rst_n low at posedge):
  - state = INTEGRATE; membrane = 0; refractory = 0; post_spike = 0; spike_count = 0; refractory counter = 0.
  - Reset overrides enable and any in-flight refractory period.
- Synaptic sum, combinational:
  - syn = sum over i of (pre_spike[i] ? weight_i : 0).
  - Width is W_WIDTH+2 bits (max 60). No weight is ever subtracted.
- State INTEGRATE, enable high:
  - leak = v >> LEAK_SHIFT.
  - v_next = v - leak + syn, computed in V_WIDTH+1 bits; saturate at 2^V_WIDTH-1.
  - If v_next >= THRESHOLD:
    - membrane <= 0; post_spike <= 1; refractory <= 1.
    - counter <= REFRAC_CYCLES; state <= REFRACT.
    - spike_count <= spike_count+1, saturating at 255.
  - Otherwise: membrane <= v_next; post_spike <= 0.
- Latency: post_spike is high in the cycle after the clk edge that sampled the threshold-crossing inputs, i.e. 1 cycle after the causing pre_spike.
- State REFRACT, enable high:
  - pre_spike ignored; membrane held at 0; post_spike <= 0.
  - counter decrements each cycle.
  - When counter == 1 at the edge: state <= INTEGRATE, refractory <= 0.
  - Net effect: refractory is high for exactly REFRAC_CYCLES cycles, starting in the same cycle as post_spike.
- First integrating edge after REFRACT starts from v = 0; inputs on that edge count.
- enable low:
  - state, membrane, counter and spike_count all hold.
  - post_spike forced 0 on the next edge; a pulse never stretches.
- Simultaneous events:
  - Spikes from all inputs in one cycle sum in one step.
  - Only one fire per edge regardless of the syn magnitude.
- post_spike can never assert on consecutive cycles, because REFRAC_CYCLES >= 1.

Decomposition:
- Shared package stdp_pkg:
  - constants NUM_PRE, W_WIDTH, V_WIDTH.
  - typedef weight_t (logic [W_WIDTH-1:0]).
  - typedef vmem_t (logic [V_WIDTH-1:0]).
  - enum neuron_state_t {INTEGRATE, REFRACT}.
  - The STDP stage reuses the same NUM_PRE/W_WIDTH constants and the weight packing order.
- One natural sub-module: syn_sum.
  - Combinational masked adder tree; NUM_PRE weights in, syn out.
  - Unit-testable in isolation.

Test Plan:
- Instant fire:
  - Stimulus: weight=16'hFFFF, pre_spike=4'b1111 for one cycle from v=0.
  - Response: syn=60, post_spike high next cycle, membrane=0, refractory high 4 cycles, spike_count=1.
  - A repeat spike issued during refractory produces no fire and membrane stays 0.
- Leak equilibrium:
  - Stimulus: weight=16'h1000, pre_spike=4'b0001 continuously.
  - Response: membrane 1,2,...,7,8 then holds at 8 forever; no post_spike.
- Decay:
  - Stimulus: weight=16'hC000, pre_spike[0] for 2 cycles then 0.
  - Response: membrane 12, 23, then 21, 19, 17, 15, 14, 13, 12; no fire.
- Enable freeze:
  - Stimulus: reach membrane=23 as in Decay, then drop enable for 5 cycles with pre_spike=4'b1111.
  - Response: membrane stays 23 and no post_spike while enable is low. On re-enable with pre_spike=4'b1111, fire next cycle.
- Reset mid-refractory:
  - Stimulus: assert rst_n=0 for 1 cycle, 2 cycles into REFRACT.
  - Response: refractory=0, spike_count=0, state INTEGRATE. The next 4'b1111/16'hFFFF cycle fires immediately.
- Saturation:
  - Stimulus: THRESHOLD=255, weight=16'hFFFF, pre_spike=4'b1111 held.
  - Response: membrane saturates at 255, never wraps, fires on the crossing edge.
  - Also: 300 fires (THRESHOLD=32 run) leave spike_count at 255.

Source files
------------

// File: rtl/lif_neuron_pkg.sv
// rtl/lif_neuron_pkg.sv - shared widths, types and weight-bus helper for the neuron/STDP loop
//
// Contents:
//   NUM_PRE, W_WIDTH, V_WIDTH   : synapse count, weight width, membrane width
//   SYN_WIDTH, CNT_WIDTH        : synaptic-sum width, fire-counter width
//   weight_t, vmem_t, syn_t     : scalar types for weights, membrane and synaptic sum
//   neuron_state_t              : INTEGRATE / REFRACT
//   get_weight()                : extracts weight i from the packed bus (weight 0 in the top nibble)
package lif_neuron_pkg;

  localparam int NUM_PRE   = 4;
  localparam int W_WIDTH   = 4;
  localparam int V_WIDTH   = 8;
  // Four weights of at most 15 sum to at most 60, which fits in W_WIDTH+2 bits.
  localparam int SYN_WIDTH = W_WIDTH + 2;
  localparam int CNT_WIDTH = 8;

  typedef logic [W_WIDTH-1:0]   weight_t;
  typedef logic [V_WIDTH-1:0]   vmem_t;
  typedef logic [SYN_WIDTH-1:0] syn_t;

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } neuron_state_t;

  // Packing order shared with the STDP stage: index 0 lives in the most
  // significant nibble, index NUM_PRE-1 in the least significant one.
  function automatic weight_t get_weight(input logic [NUM_PRE*W_WIDTH-1:0] bus,
                                         input int idx);
    return bus[(NUM_PRE-1-idx)*W_WIDTH +: W_WIDTH];
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// rtl/lif_neuron_if.sv - neuron input/output bundle with master and slave modports
//
// Signals:
//   enable      : advance the neuron when high, freeze when low
//   pre_spike   : NUM_PRE presynaptic strobes for the current cycle
//   weight      : packed NUM_PRE x W_WIDTH weights (index 0 in the top nibble)
//   post_spike  : registered one-cycle fire pulse
//   membrane    : current membrane potential register
//   refractory  : high while the neuron is refractory
//   spike_count : saturating count of fires since reset
// Modports:
//   master : drives enable/pre_spike/weight, observes neuron outputs
//   slave  : the neuron itself
interface lif_neuron_if;
  import lif_neuron_pkg::*;

  logic                       enable;
  logic [NUM_PRE-1:0]         pre_spike;
  logic [NUM_PRE*W_WIDTH-1:0] weight;
  logic                       post_spike;
  vmem_t                      membrane;
  logic                       refractory;
  logic [CNT_WIDTH-1:0]       spike_count;

  modport master (
    output enable,
    output pre_spike,
    output weight,
    input  post_spike,
    input  membrane,
    input  refractory,
    input  spike_count
  );

  modport slave (
    input  enable,
    input  pre_spike,
    input  weight,
    output post_spike,
    output membrane,
    output refractory,
    output spike_count
  );

endinterface

// File: rtl/lif_neuron_syn_sum.sv
// rtl/lif_neuron_syn_sum.sv - combinational masked adder over the presynaptic weights
//
// Ports:
//   pre_spike_i : NUM_PRE spike strobes; a set bit admits the matching weight
//   weight_i    : packed weight bus (index 0 in the top nibble)
//   syn_o       : sum of the admitted weights, SYN_WIDTH bits, never negative
module lif_neuron_syn_sum
  import lif_neuron_pkg::*;
(
  input  logic [NUM_PRE-1:0]         pre_spike_i,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight_i,
  output syn_t                       syn_o
);

  always_comb begin
    syn_o = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (pre_spike_i[i]) begin
        syn_o = syn_o + syn_t'(get_weight(weight_i, i));
      end
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory period
//
// Parameters:
//   THRESHOLD     : fire when the next membrane value reaches this (1..2^V_WIDTH-1)
//   LEAK_SHIFT    : per-cycle leak is v >> LEAK_SHIFT
//   REFRAC_CYCLES : cycles the refractory output stays high after a fire (1..15)
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   nrn   : slave side of lif_neuron_if (enable/pre_spike/weight in,
//           post_spike/membrane/refractory/spike_count out, all registered)
module lif_neuron
  import lif_neuron_pkg::*;
#(
  parameter int THRESHOLD     = 32,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  lif_neuron_if.slave  nrn
);

  localparam vmem_t      THRESH_V = vmem_t'(THRESHOLD);
  localparam logic [3:0] REFRAC_V = 4'(REFRAC_CYCLES);

  neuron_state_t        state_q;
  vmem_t                membrane_q;
  logic                 post_spike_q;
  logic                 refractory_q;
  logic [3:0]           refrac_cnt_q;
  logic [CNT_WIDTH-1:0] spike_count_q;

  syn_t              syn;
  vmem_t             leak;
  logic [V_WIDTH:0]  v_sum;
  vmem_t             membrane_d;

  lif_neuron_syn_sum u_syn_sum (
    .pre_spike_i (nrn.pre_spike),
    .weight_i    (nrn.weight),
    .syn_o       (syn)
  );

  // v - leak cannot underflow since leak <= v; the extra top bit of v_sum
  // catches overflow from adding syn, which then clamps to all-ones.
  always_comb begin
    leak       = membrane_q >> LEAK_SHIFT;
    v_sum      = {1'b0, membrane_q - leak}
               + {{(V_WIDTH+1-SYN_WIDTH){1'b0}}, syn};
    membrane_d = v_sum[V_WIDTH] ? '1 : v_sum[V_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INTEGRATE;
      membrane_q    <= '0;
      post_spike_q  <= 1'b0;
      refractory_q  <= 1'b0;
      refrac_cnt_q  <= '0;
      spike_count_q <= '0;
    end else if (!nrn.enable) begin
      // Everything freezes except the pulse, which must not stretch.
      post_spike_q <= 1'b0;
    end else begin
      case (state_q)
        INTEGRATE: begin
          if (membrane_d >= THRESH_V) begin
            state_q      <= REFRACT;
            membrane_q   <= '0;
            post_spike_q <= 1'b1;
            refractory_q <= 1'b1;
            refrac_cnt_q <= REFRAC_V;
            if (spike_count_q != '1) begin
              spike_count_q <= spike_count_q + 8'd1;
            end
          end else begin
            membrane_q   <= membrane_d;
            post_spike_q <= 1'b0;
          end
        end
        REFRACT: begin
          // The fire edge already counted as the first refractory cycle, so
          // leaving on counter == 1 gives exactly REFRAC_CYCLES high cycles.
          membrane_q   <= '0;
          post_spike_q <= 1'b0;
          refrac_cnt_q <= refrac_cnt_q - 4'd1;
          if (refrac_cnt_q == 4'd1) begin
            state_q      <= INTEGRATE;
            refractory_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign nrn.post_spike  = post_spike_q;
  assign nrn.membrane    = membrane_q;
  assign nrn.refractory  = refractory_q;
  assign nrn.spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - self-checking bench for lif_neuron (THRESHOLD 32 and 255 instances)
module tb_lif_neuron;
  import lif_neuron_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_r;
  logic [3:0]  pre_r;
  logic [15:0] w_r;

  always #5 clk = ~clk;

  lif_neuron_if if_a ();
  lif_neuron_if if_b ();

  assign if_a.enable    = en_r;
  assign if_a.pre_spike = pre_r;
  assign if_a.weight    = w_r;
  assign if_b.enable    = en_r;
  assign if_b.pre_spike = pre_r;
  assign if_b.weight    = w_r;

  lif_neuron #(.THRESHOLD(32), .LEAK_SHIFT(3), .REFRAC_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nrn   (if_a)
  );

  lif_neuron #(.THRESHOLD(255), .LEAK_SHIFT(3), .REFRAC_CYCLES(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .nrn   (if_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: membrane as an integer, refractory as "cycles left".
  int m_v    [2];
  int m_refr [2];
  int m_cnt  [2];
  int m_post [2];
  int m_th   [2] = '{32, 255};

  typedef struct {
    bit          en;
    logic [3:0]  pre;
    logic [15:0] w;
    int          post;
    int          mem;
    int          refr;
    int          cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit en,
                            input logic [3:0] pre, input logic [15:0] w);
    int syn;
    int vn;
    if (rst) begin
      m_v[k] = 0; m_refr[k] = 0; m_cnt[k] = 0; m_post[k] = 0;
      return;
    end
    m_post[k] = 0;
    if (!en) return;
    if (m_refr[k] > 0) begin
      m_refr[k]--;
      m_v[k] = 0;
      return;
    end
    syn = 0;
    for (int i = 0; i < 4; i++)
      if (pre[i]) syn += (int'(w) / (1 << (12 - 4*i))) % 16;
    vn = m_v[k] - m_v[k] / 8 + syn;
    if (vn > 255) vn = 255;
    if (vn >= m_th[k]) begin
      m_v[k]    = 0;
      m_post[k] = 1;
      m_refr[k] = 4;
      if (m_cnt[k] < 255) m_cnt[k]++;
    end else begin
      m_v[k] = vn;
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [3:0] pre,
                     input logic [15:0] w);
    rst_n = !rst;
    en_r  = en;
    pre_r = pre;
    w_r   = w;
    @(posedge clk);
    model_step(0, rst, en, pre, w);
    model_step(1, rst, en, pre, w);
    @(negedge clk);
    check("a.post_spike",  int'(if_a.post_spike),  m_post[0]);
    check("a.membrane",    int'(if_a.membrane),    m_v[0]);
    check("a.refractory",  int'(if_a.refractory),  int'(m_refr[0] > 0));
    check("a.spike_count", int'(if_a.spike_count), m_cnt[0]);
    check("b.post_spike",  int'(if_b.post_spike),  m_post[1]);
    check("b.membrane",    int'(if_b.membrane),    m_v[1]);
    check("b.refractory",  int'(if_b.refractory),  int'(m_refr[1] > 0));
    check("b.spike_count", int'(if_b.spike_count), m_cnt[1]);
  endtask

  initial begin
    int dec [9];
    int sat [5];
    dec = '{12, 23, 21, 19, 17, 15, 14, 13, 12};
    sat = '{60, 113, 159, 200, 235};

    // Instant fire, refractory window, ignored spikes, freeze, resume.
    tbl[0] = '{1'b1, 4'hF, 16'hFFFF, 1, 0, 1, 1};
    tbl[1] = '{1'b1, 4'hF, 16'hFFFF, 0, 0, 1, 1};
    tbl[2] = '{1'b1, 4'hF, 16'hFFFF, 0, 0, 1, 1};
    tbl[3] = '{1'b1, 4'hF, 16'hFFFF, 0, 0, 1, 1};
    tbl[4] = '{1'b1, 4'h0, 16'hFFFF, 0, 0, 0, 1};
    tbl[5] = '{1'b1, 4'h1, 16'h1000, 0, 1, 0, 1};
    tbl[6] = '{1'b0, 4'hF, 16'hFFFF, 0, 1, 0, 1};
    tbl[7] = '{1'b1, 4'h1, 16'h1000, 0, 2, 0, 1};

    rst_n = 1'b0; en_r = 1'b0; pre_r = '0; w_r = '0;
    cyc(1, 0, 4'h0, 16'h0);
    cyc(1, 1, 4'hF, 16'hFFFF);
    check("reset.post",  int'(if_a.post_spike),  0);
    check("reset.mem",   int'(if_a.membrane),    0);
    check("reset.refr",  int'(if_a.refractory),  0);
    check("reset.count", int'(if_a.spike_count), 0);

    for (int i = 0; i < 8; i++) begin
      cyc(0, tbl[i].en, tbl[i].pre, tbl[i].w);
      check($sformatf("tbl%0d.post", i),  int'(if_a.post_spike),  tbl[i].post);
      check($sformatf("tbl%0d.mem", i),   int'(if_a.membrane),    tbl[i].mem);
      check($sformatf("tbl%0d.refr", i),  int'(if_a.refractory),  tbl[i].refr);
      check($sformatf("tbl%0d.count", i), int'(if_a.spike_count), tbl[i].cnt);
    end

    // Leak equilibrium at 8.
    cyc(1, 1, 4'h0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 4'h1, 16'h1000);
      check("equil.mem",  int'(if_a.membrane), (i < 8) ? i + 1 : 8);
      check("equil.post", int'(if_a.post_spike), 0);
    end

    // Decay after two input cycles.
    cyc(1, 1, 4'h0, 16'h0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, (i < 2) ? 4'h1 : 4'h0, 16'hC000);
      check("decay.mem",  int'(if_a.membrane), dec[i]);
      check("decay.post", int'(if_a.post_spike), 0);
    end

    // Enable freeze at 23, then fire on re-enable.
    cyc(1, 1, 4'h0, 16'h0);
    cyc(0, 1, 4'h1, 16'hC000);
    cyc(0, 1, 4'h1, 16'hC000);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 4'hF, 16'hC000);
      check("freeze.mem",  int'(if_a.membrane), 23);
      check("freeze.post", int'(if_a.post_spike), 0);
    end
    cyc(0, 1, 4'hF, 16'hC000);
    check("reenable.post",  int'(if_a.post_spike), 1);
    check("reenable.count", int'(if_a.spike_count), 1);

    // Reset two cycles into the refractory period.
    cyc(0, 1, 4'h0, 16'h0);
    cyc(0, 1, 4'h0, 16'h0);
    check("midrefr.refr", int'(if_a.refractory), 1);
    cyc(1, 1, 4'hF, 16'hFFFF);
    check("midrst.refr",  int'(if_a.refractory),  0);
    check("midrst.count", int'(if_a.spike_count), 0);
    cyc(0, 1, 4'hF, 16'hFFFF);
    check("postrst.post",  int'(if_a.post_spike),  1);
    check("postrst.count", int'(if_a.spike_count), 1);

    // Saturation on the THRESHOLD=255 instance.
    cyc(1, 1, 4'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 4'hF, 16'hFFFF);
      check("sat.mem",  int'(if_b.membrane), sat[i]);
      check("sat.post", int'(if_b.post_spike), 0);
    end
    cyc(0, 1, 4'hF, 16'hFFFF);
    check("sat.fire", int'(if_b.post_spike), 1);
    check("sat.zero", int'(if_b.membrane), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
          4'($urandom), 16'($urandom));
    end

    // Many fires: counter saturates.
    cyc(1, 1, 4'h0, 16'h0);
    for (int i = 0; i < 1600; i++) cyc(0, 1, 4'hF, 16'hFFFF);
    check("count.sat", int'(if_a.spike_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
